// File: rtl/imem_load_fetch_ctrl.sv
// imem_load_fetch_ctrl: arbitrates the instruction-memory port between the program loader and the fetch stage.
// Optional IMEM_CLEAR_EN: every load is preceded by a NOP fill of the whole memory.
`default_nettype none

module imem_load_fetch_ctrl #(
  parameter int          DEPTH    = 32,
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] NOP_WORD = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_mode,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [ADDR_W:0]   load_count,
  output logic              err_overflow,
  output logic              err_oob
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

`ifdef IMEM_CLEAR_EN
  localparam state_e START_STATE = S_CLEAR;
`else
  localparam state_e START_STATE = S_LOAD;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              oob_q, oob_d;
  logic              pend_q, pend_d;
  logic              pend_oob_q, pend_oob_d;
  logic [31:0]       data_q, data_d;
  logic              addr_oob;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      oob_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_oob_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      oob_q      <= oob_d;
      pend_q     <= pend_d;
      pend_oob_q <= pend_oob_d;
      data_q     <= data_d;
    end
  end

  // The response is taken straight from the memory in the cycle after grant, then held.
  assign fetch_data = pend_q ? (pend_oob_q ? NOP_WORD : mem_rdata) : data_q;
  assign data_d     = fetch_data;
  assign addr_oob   = {1'b0, fetch_addr} >= DEPTH_CNT;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    oob_d      = oob_q;
    pend_d     = 1'b0;
    pend_oob_d = 1'b0;
    ld_ready   = 1'b0;
    fetch_gnt  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_mode   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = START_STATE;
          ptr_d   = '0;
          count_d = '0;
        end
      end

      S_LOAD: begin
        ld_ready  = 1'b1;
        mem_mode  = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = ld_data;
        mem_we    = ld_valid;
        if (load_start) begin
          state_d = START_STATE;
          ptr_d   = '0;
          count_d = '0;
        end else if (ld_valid) begin
          ptr_d = ptr_q + 1'b1;
          if (count_q < DEPTH_CNT) begin
            count_d = count_q + 1'b1;
          end
          if (ld_last) begin
            state_d = S_RUN;
          end else if (ptr_q == LAST_ADDR) begin
            ovf_d   = 1'b1;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        fetch_gnt = fetch_req & ~load_start;
        if (load_start) begin
          state_d = START_STATE;
          ptr_d   = '0;
          count_d = '0;
        end else if (fetch_req) begin
          pend_d     = 1'b1;
          pend_oob_d = addr_oob;
          if (addr_oob) begin
            oob_d = 1'b1;
          end else begin
            mem_addr = fetch_addr;
          end
        end
      end

`ifdef IMEM_CLEAR_EN
      S_CLEAR: begin
        mem_mode  = 1'b0;
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = NOP_WORD;
        if (load_start) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_ADDR) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q == S_LOAD) || (state_q == S_CLEAR);
  assign fetch_valid  = pend_q;
  assign load_count   = count_q;
  assign err_overflow = ovf_q;
  assign err_oob      = oob_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_load_fetch_ctrl.sv
// tb_imem_load_fetch_ctrl: randomized directed bench for imem_load_fetch_ctrl with a memory and a program-image model.
`default_nettype none

module tb_imem_load_fetch_ctrl;

  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 5;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic [31:0]       ld_data = '0;
  logic              ld_last = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              mem_clr = 1'b1;
  logic [31:0]       mem_rdata;
  wire               ld_ready, fetch_gnt, fetch_valid, mem_we, mem_mode, busy, err_overflow, err_oob;
  wire [31:0]        fetch_data, mem_wdata;
  wire [ADDR_W-1:0]  mem_addr;
  wire [ADDR_W:0]    load_count;

  imem_load_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_mode(mem_mode),
    .mem_rdata(mem_rdata), .busy(busy), .load_count(load_count),
    .err_overflow(err_overflow), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous write, registered read in read mode.
  logic [31:0] mem [0:31];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 + i;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_mode) mem_rdata <= mem[mem_addr];
    end
  end

  // Reference: expected program image and controller-visible status.
  logic [31:0] img [0:31];
  int          m_ptr, m_cnt;
  bit          m_loading, m_ovf, m_oob, pend_valid;
  logic [31:0] pend_data, last_data;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      if (mem_we && (mem_mode !== 1'b0)) begin
        fails++;
        $error("FAIL proto: mem_we asserted with mem_mode=%0b", mem_mode);
      end
      if (busy && (fetch_gnt !== 1'b0)) begin
        fails++;
        $error("FAIL proto: fetch_gnt asserted while busy");
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic void model_start();
    m_ptr = 0;
    m_cnt = 0;
    m_loading = 1'b1;
`ifdef IMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) img[i] = NOP;
`endif
  endfunction

  task automatic wait_ready();
    int waited;
    int exp_wait;
    waited = 0;
`ifdef IMEM_CLEAR_EN
    exp_wait = DEPTH;
`else
    exp_wait = 0;
`endif
    #1;
    while (!ld_ready && waited <= DEPTH + 4) begin
      step();
      #1;
      waited++;
    end
    chk("ld_ready_latency", waited, exp_wait);
    chk("load_count_start", load_count, (ADDR_W+1)'(0));
  endtask

  task automatic start_load();
    load_start = 1'b1;
    model_start();
    step();
    load_start = 1'b0;
    wait_ready();
  endtask

  task automatic load_words(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        #1;
        chk("idle_no_we", mem_we, 1'b0);
        step();
      end
      ld_valid = 1'b1;
      ld_data  = (i == 0) ? 32'h3C22_000E : $urandom();
      ld_last  = use_last && (i == n - 1);
      #1;
      chk("ld_ready", ld_ready, m_loading);
      chk("mem_we", mem_we, m_loading);
      if (m_loading) begin
        chk("wr_addr", mem_addr, ADDR_W'(m_ptr));
        chk("wr_mode", mem_mode, 1'b0);
        img[m_ptr] = ld_data;
        m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
        if (ld_last) m_loading = 1'b0;
        else if (m_ptr == DEPTH - 1) begin
          m_loading = 1'b0;
          m_ovf = 1'b1;
        end
        m_ptr++;
      end
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    chk("busy_after_load", busy, m_loading);
    chk("load_count", load_count, (ADDR_W+1)'(m_cnt));
    chk("err_overflow", err_overflow, m_ovf);
  endtask

  task automatic fetch_cycle(input bit req, input logic [ADDR_W-1:0] a);
    fetch_req  = req;
    fetch_addr = a;
    #1;
    chk("fetch_valid", fetch_valid, pend_valid);
    chk("fetch_data", fetch_data, pend_valid ? pend_data : last_data);
    chk("fetch_gnt", fetch_gnt, req);
    if (req && a < DEPTH) chk("rd_addr", mem_addr, a);
    if (pend_valid) last_data = pend_data;
    pend_valid = req;
    if (req) begin
      pend_data = (a < DEPTH) ? img[a] : NOP;
      if (a >= DEPTH) m_oob = 1'b1;
    end
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) img[i] = 32'hA500_0000 + i;
    m_ptr = 0; m_cnt = 0; m_loading = 0; m_ovf = 0; m_oob = 0;
    pend_valid = 0; pend_data = '0; last_data = '0;

    step();
    step();
    mem_clr   = 1'b0;
    fetch_req = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_fetch_gnt", fetch_gnt, 1'b0);
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_fetch_data", fetch_data, 32'h0);
    chk("rst_mem_mode", mem_mode, 1'b1);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_load_count", load_count, (ADDR_W+1)'(0));
    chk("rst_err_overflow", err_overflow, 1'b0);
    chk("rst_err_oob", err_oob, 1'b0);
    reset     = 1'b0;
    fetch_req = 1'b0;
    step();
    #1;
    chk("idle_fetch_valid", fetch_valid, 1'b0);

    // 14-word program, then single, back-to-back and random fetches
    start_load();
    load_words(14, 1'b1);
    fetch_cycle(1'b1, 5'd3);
    fetch_cycle(1'b0, 5'd0);
    fetch_cycle(1'b0, 5'd0);
    fetch_cycle(1'b1, 5'd0);
    fetch_cycle(1'b1, 5'd1);
    fetch_cycle(1'b1, 5'd2);
    fetch_cycle(1'b0, 5'd0);
    fetch_cycle(1'b1, 5'd31);
    fetch_cycle(1'b0, 5'd0);
    chk("err_oob_set", err_oob, m_oob);
    repeat (40) fetch_cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)));
    fetch_cycle(1'b0, 5'd0);

    // Overrun: DEPTH+1 words without ld_last
    start_load();
    load_words(DEPTH + 1, 1'b0);
    repeat (20) fetch_cycle(1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)));
    fetch_cycle(1'b0, 5'd0);

    // Short program: words past it are stale (or NOP when cleared)
    start_load();
    load_words(5, 1'b1);
    for (int a = 0; a < DEPTH; a++) fetch_cycle(1'b1, ADDR_W'(a));
    fetch_cycle(1'b0, 5'd0);

    // load_start beats fetch_req; the previous grant still responds
    fetch_cycle(1'b1, 5'd7);
    fetch_req  = 1'b1;
    fetch_addr = 5'd2;
    load_start = 1'b1;
    #1;
    chk("ls_prio_gnt", fetch_gnt, 1'b0);
    chk("ls_prev_valid", fetch_valid, 1'b1);
    chk("ls_prev_data", fetch_data, pend_data);
    last_data  = pend_data;
    pend_valid = 1'b0;
    model_start();
    step();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    #1;
    chk("ls_busy", busy, 1'b1);
    chk("ls_no_valid", fetch_valid, 1'b0);
    chk("ls_data_hold", fetch_data, last_data);
    wait_ready();
    load_words(6, 1'b1);
    repeat (12) fetch_cycle(1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)));
    fetch_cycle(1'b0, 5'd0);

    // Reset in the middle of a load
    start_load();
    load_words(3, 1'b0);
    reset = 1'b1;
    step();
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ld_ready", ld_ready, 1'b0);
    chk("mid_rst_count", load_count, (ADDR_W+1)'(0));
    chk("mid_rst_err_overflow", err_overflow, 1'b0);
    chk("mid_rst_err_oob", err_oob, 1'b0);
    chk("mid_rst_fetch_data", fetch_data, 32'h0);
    chk("mid_rst_mem_mode", mem_mode, 1'b1);
    reset = 1'b0;
    m_loading = 0; m_ovf = 0; m_oob = 0; m_cnt = 0;
    pend_valid = 0; last_data = '0;
    step();
    start_load();
    load_words(4, 1'b1);
    for (int a = 0; a < 8; a++) fetch_cycle(1'b1, ADDR_W'(a));
    fetch_cycle(1'b0, 5'd0);
    #1;
    chk("final_err_oob", err_oob, m_oob);

    $display("%0d/%0d checks passed", passes, checks);
    if (fails != 0) $display("FAIL: %0d mismatches", fails);
    else $display("PASS");
    $finish;
  end

endmodule

`default_nettype wire
